// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the multiplexed BCD display.
// Patterns are active-low {dp,g,f,e,d,c,b,a} with dp held off.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes go dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       bcd,
  output logic [7:0] seg
);

  // Pattern lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_counter_scan.sv
// N-digit BCD up/down counter with prescaled stepping, driving a scanned
// common-anode 7-segment display with optional leading-zero blanking.
module seg7_bcd_counter_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 16777216,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_LZ   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [7:0]              c,
  output logic [NUM_DIGITS-1:0]   en
);

  localparam int VW     = 4 * NUM_DIGITS;
  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [STEP_W-1:0]     step_cnt_r;
  logic [VW-1:0]         value_r;
  logic                  wrap_r;
  logic [SCAN_W-1:0]     scan_cnt_r;
  logic [IDX_W-1:0]      scan_idx_r;
  logic [7:0]            c_r;
  logic [NUM_DIGITS-1:0] en_r;

  logic                  tick_s;
  logic [VW-1:0]         next_value_s;
  logic                  carry_s;
  logic [NUM_DIGITS-1:0] blank_s;
  logic [NUM_DIGITS-1:0] en_next_s;
  bcd_t                  cur_digit_s;
  logic                  cur_blank_s;
  logic [7:0]            seg_s;

  // Ripple +/-1 across all digits; MSB of the result is the wrap-out carry/borrow.
  function automatic logic [VW:0] bcd_step(input logic [VW-1:0] v, input logic dir_up);
    logic [VW-1:0] nv;
    logic          cy;
    bcd_t          d;
    nv = v;
    cy = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (!cy) begin
        nv[4*i +: 4] = d;
      end else if (dir_up) begin
        if (d == 4'd9) begin
          nv[4*i +: 4] = 4'd0;
        end else begin
          nv[4*i +: 4] = d + 4'd1;
          cy           = 1'b0;
        end
      end else begin
        if (d == 4'd0) begin
          nv[4*i +: 4] = 4'd9;
        end else begin
          nv[4*i +: 4] = d - 4'd1;
          cy           = 1'b0;
        end
      end
    end
    return {cy, nv};
  endfunction

  assign tick_s = (step_cnt_r == STEP_W'(STEP_DIV - 1));

  // Next count value and wrap indication
  always_comb begin
    {carry_s, next_value_s} = bcd_step(value_r, up);
  end

  // Step prescaler; a load restarts the step period
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_r <= {STEP_W{1'b0}};
    end else if (load || tick_s) begin
      step_cnt_r <= {STEP_W{1'b0}};
    end else begin
      step_cnt_r <= step_cnt_r + STEP_W'(1);
    end
  end

  // Counter: load beats a step, run gates stepping only
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= {VW{1'b0}};
      wrap_r  <= 1'b0;
    end else if (load) begin
      value_r <= load_val;
      wrap_r  <= 1'b0;
    end else if (tick_s && run) begin
      value_r <= next_value_s;
      wrap_r  <= carry_s;
    end else begin
      wrap_r  <= 1'b0;
    end
  end

  // Scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      scan_idx_r <= {IDX_W{1'b0}};
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      if (scan_idx_r == IDX_W'(NUM_DIGITS - 1)) begin
        scan_idx_r <= {IDX_W{1'b0}};
      end else begin
        scan_idx_r <= scan_idx_r + IDX_W'(1);
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Leading-zero mask: a digit blanks when it and every higher digit are zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_s    = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (value_r[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0)) begin
        blank_s[i] = zero_above;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  // Select the digit under the current scan slot
  always_comb begin
    cur_digit_s = value_r[3:0];
    cur_blank_s = 1'b0;
    en_next_s   = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_r == IDX_W'(i)) begin
        cur_digit_s  = value_r[4*i +: 4];
        cur_blank_s  = blank_s[i];
        en_next_s[i] = 1'b0;
      end else begin
        en_next_s[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_digit_s),
    .seg (seg_s)
  );

  // Segments and anodes share one register stage so they always switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r  <= SEG_BLANK;
      en_r <= {NUM_DIGITS{1'b1}};
    end else begin
      c_r  <= cur_blank_s ? SEG_BLANK : seg_s;
      en_r <= en_next_s;
    end
  end

  assign value = value_r;
  assign wrap  = wrap_r;
  assign c     = c_r;
  assign en    = en_r;

endmodule

// File: tb/tb_seg7_bcd_counter_scan.sv
// Self-checking bench: two 2-digit instances (plain and leading-zero blanked)
// compared against an integer-arithmetic model of the counter and display scan.
module tb_seg7_bcd_counter_scan;

  logic       clk = 1'b0;
  logic       rst, run, up, load;
  logic [7:0] load_val;
  logic [7:0] value_a, value_b, c_a, c_b;
  logic       wrap_a, wrap_b;
  logic [1:0] en_a, en_b;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seg7_bcd_counter_scan #(.NUM_DIGITS(2), .STEP_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .run(run), .up(up), .load(load), .load_val(load_val),
    .value(value_a), .wrap(wrap_a), .c(c_a), .en(en_a)
  );

  seg7_bcd_counter_scan #(.NUM_DIGITS(2), .STEP_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .run(run), .up(up), .load(load), .load_val(load_val),
    .value(value_b), .wrap(wrap_b), .c(c_b), .en(en_b)
  );

  function automatic logic [7:0] seg_of(int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int bcd2int(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(int v);
    int t_hi, t_lo;
    logic [3:0] h, l;
    t_hi = v / 10;
    t_lo = v % 10;
    h = t_hi[3:0];
    l = t_lo[3:0];
    return {h, l};
  endfunction

  // Reference model: count kept as an integer 0..99, display slot as an integer index
  int         m_val, m_pre, m_sc, m_idx;
  logic       m_wrap;
  logic [7:0] m_c, m_cb;
  logic [1:0] m_en;

  always @(posedge clk) begin
    if (rst) begin
      m_val <= 0; m_pre <= 0; m_sc <= 0; m_idx <= 0;
      m_wrap <= 1'b0; m_c <= 8'hFF; m_cb <= 8'hFF; m_en <= 2'b11;
    end else begin
      if (load) begin
        m_val  <= bcd2int(load_val);
        m_wrap <= 1'b0;
        m_pre  <= 0;
      end else begin
        m_pre <= (m_pre == 3) ? 0 : m_pre + 1;
        if (m_pre == 3 && run) begin
          if (up) begin
            m_val  <= (m_val + 1) % 100;
            m_wrap <= (m_val == 99);
          end else begin
            m_val  <= (m_val + 99) % 100;
            m_wrap <= (m_val == 0);
          end
        end else begin
          m_wrap <= 1'b0;
        end
      end
      m_sc <= (m_sc + 1) % 2;
      if (m_sc == 1) m_idx <= (m_idx + 1) % 2;
      m_c  <= seg_of((m_idx == 0) ? m_val % 10 : m_val / 10);
      m_cb <= (m_idx == 1 && m_val < 10) ? 8'hFF : seg_of((m_idx == 0) ? m_val % 10 : m_val / 10);
      m_en <= (m_idx == 0) ? 2'b10 : 2'b01;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    repeat (3) cyc();
    total++;
    if (value_a !== 8'h00 || wrap_a !== 1'b0 || c_a !== 8'hFF || en_a !== 2'b11) begin
      bad++;
      $display("FAIL reset_a: value=%h wrap=%b c=%h en=%b, want 00 0 ff 11", value_a, wrap_a, c_a, en_a);
    end
    total++;
    if (value_b !== 8'h00 || wrap_b !== 1'b0 || c_b !== 8'hFF || en_b !== 2'b11) begin
      bad++;
      $display("FAIL reset_b: value=%h wrap=%b c=%h en=%b, want 00 0 ff 11", value_b, wrap_b, c_b, en_b);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (en_a !== 2'b10 || c_a !== 8'hC0 || en_b !== 2'b10 || c_b !== 8'hC0) begin
      bad++;
      $display("FAIL first_scan: en_a=%b c_a=%h en_b=%b c_b=%h, want 10 c0 10 c0", en_a, c_a, en_b, c_b);
    end
  endtask

  task automatic test_random(int n);
    int unsigned r;
    logic [3:0]  hi, lo;
    for (int k = 0; k < n; k++) begin
      run  = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 1) == 1);
      load = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9); hi = r[3:0];
      r = $urandom_range(0, 9); lo = r[3:0];
      load_val = {hi, lo};
      cyc();
      total++;
      if (value_a !== int2bcd(m_val) || wrap_a !== m_wrap || c_a !== m_c || en_a !== m_en) begin
        bad++;
        $display("FAIL random_a cyc %0d: value=%h wrap=%b c=%h en=%b, want %h %b %h %b",
                 k, value_a, wrap_a, c_a, en_a, int2bcd(m_val), m_wrap, m_c, m_en);
      end
      total++;
      if (value_b !== int2bcd(m_val) || wrap_b !== m_wrap || c_b !== m_cb || en_b !== m_en) begin
        bad++;
        $display("FAIL random_b cyc %0d: value=%h wrap=%b c=%h en=%b, want %h %b %h %b",
                 k, value_b, wrap_b, c_b, en_b, int2bcd(m_val), m_wrap, m_cb, m_en);
      end
    end
    rst = 1'b0; load = 1'b0;
    cyc();
  endtask

  task automatic test_wrap_up();
    logic saw99, got;
    run = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h98;
    cyc();
    load = 1'b0;
    total++;
    if (value_a !== 8'h98 || wrap_a !== 1'b0) begin
      bad++;
      $display("FAIL wrap_up_load: value=%h wrap=%b, want 98 0", value_a, wrap_a);
    end
    saw99 = 1'b0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cyc();
      if (value_a === 8'h99) saw99 = 1'b1;
      if (wrap_a === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wrap_up_timeout: wrap=%b value=%h, want wrap 1 within 20 cycles", wrap_a, value_a);
    end else begin
      total++;
      if (value_a !== 8'h00 || !saw99) begin
        bad++;
        $display("FAIL wrap_up_value: value=%h saw99=%b, want 00 1", value_a, saw99);
      end
      cyc();
      total++;
      if (wrap_a !== 1'b0) begin
        bad++;
        $display("FAIL wrap_up_pulse: wrap=%b one cycle later, want 0", wrap_a);
      end
    end
  endtask

  task automatic test_down();
    run = 1'b1; up = 1'b0; load = 1'b1; load_val = 8'h10;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 10 && value_a === 8'h10; k++) cyc();
    total++;
    if (value_a !== 8'h09 || wrap_a !== 1'b0) begin
      bad++;
      $display("FAIL down_borrow: value=%h wrap=%b, want 09 0", value_a, wrap_a);
    end
    load = 1'b1; load_val = 8'h00;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 10 && value_a === 8'h00; k++) cyc();
    total++;
    if (value_a !== 8'h99 || wrap_a !== 1'b1) begin
      bad++;
      $display("FAIL down_wrap: value=%h wrap=%b, want 99 1", value_a, wrap_a);
    end
  endtask

  task automatic test_hold();
    logic [7:0] v0;
    logic [1:0] en_seq [0:19];
    run = 1'b0;
    v0 = int2bcd(m_val);
    for (int k = 0; k < 20; k++) begin
      cyc();
      en_seq[k] = en_a;
      total++;
      if (value_a !== v0 || wrap_a !== 1'b0 || en_a !== m_en) begin
        bad++;
        $display("FAIL hold cyc %0d: value=%h wrap=%b en=%b, want %h 0 %b", k, value_a, wrap_a, en_a, v0, m_en);
      end
      if (k >= 2) begin
        total++;
        if (en_seq[k] === en_seq[k-2] || (en_seq[k] !== 2'b10 && en_seq[k] !== 2'b01)) begin
          bad++;
          $display("FAIL hold_scan cyc %0d: en=%b two cycles earlier=%b, want a different single-low pattern",
                   k, en_seq[k], en_seq[k-2]);
        end
      end
    end
  endtask

  task automatic test_load_on_tick();
    int n;
    run = 1'b1; up = 1'b1;
    for (int k = 0; k < 8 && m_pre != 3; k++) cyc();
    load = 1'b1; load_val = 8'h42;
    cyc();
    load = 1'b0;
    total++;
    if (value_a !== 8'h42 || wrap_a !== 1'b0) begin
      bad++;
      $display("FAIL load_on_tick: value=%h wrap=%b, want 42 0", value_a, wrap_a);
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n++;
      if (value_a !== 8'h42) break;
    end
    total++;
    if (value_a !== 8'h43 || n != 4) begin
      bad++;
      $display("FAIL load_next_step: value=%h after %0d cycles, want 43 after 4", value_a, n);
    end
  endtask

  task automatic test_blank();
    logic seen_hi, seen_lo;
    run = 1'b0; load = 1'b1; load_val = 8'h05;
    cyc();
    load = 1'b0;
    cyc();
    seen_hi = 1'b0; seen_lo = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++;
      if (en_b === 2'b01) begin
        seen_hi = 1'b1;
        if (c_b !== 8'hFF || c_a !== 8'hC0) begin
          bad++;
          $display("FAIL blank_hi: c_b=%h c_a=%h, want ff c0", c_b, c_a);
        end
      end else begin
        seen_lo = 1'b1;
        if (en_b !== 2'b10 || c_b !== 8'h92 || c_a !== 8'h92) begin
          bad++;
          $display("FAIL blank_lo: en_b=%b c_b=%h c_a=%h, want 10 92 92", en_b, c_b, c_a);
        end
      end
    end
    total++;
    if (!(seen_hi && seen_lo)) begin
      bad++;
      $display("FAIL blank_slots: seen_hi=%b seen_lo=%b, want 1 1", seen_hi, seen_lo);
    end
    run = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h37;
    cyc();
    load = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    total++;
    if (value_a !== 8'h00 || wrap_a !== 1'b0 || c_a !== 8'hFF || en_a !== 2'b11 ||
        value_b !== 8'h00 || c_b !== 8'hFF || en_b !== 2'b11) begin
      bad++;
      $display("FAIL midscan_reset: a=%h/%b/%h/%b b=%h/%h/%b, want 00/0/ff/11 00/ff/11",
               value_a, wrap_a, c_a, en_a, value_b, c_b, en_b);
    end
    rst = 1'b0;
    cyc();
    total++;
    if (en_a !== 2'b10 || c_a !== 8'hC0 || en_b !== 2'b10 || c_b !== 8'hC0) begin
      bad++;
      $display("FAIL midscan_restart: en_a=%b c_a=%h en_b=%b c_b=%h, want 10 c0 10 c0", en_a, c_a, en_b, c_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random(400);
    test_wrap_up();
    test_down();
    test_hold();
    test_load_on_tick();
    test_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
